shift_framer: RTL and testbench
===============================

SHIFT_FRAMER -- requirements
Module: shift_framer

Interface
REQ-001 The block SHALL have exactly one parameter: GAP_CYCLES, default 1, the number of idle cycles inserted after each stop bit (legal range 0-15).
REQ-002 The block SHALL have one clock and one reset. The reset is asynchronous and active-high. The ports SHALL be as follows, clock and reset first:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous active-high reset
- din  input  4  parallel word to serialise
- din_valid  input  1  din holds a word to send
- din_ready  output  1  block can accept a word this cycle
- shift_en  output  1  a frame bit is on shift_in this cycle; feeds the downstream shift register's shift enable
- shift_in  output  1  serial frame bit; feeds the downstream shift register's serial input
- busy  output  1  a frame or gap is in progress
- frame_done  output  1  one-cycle pulse coincident with the stop bit

Function
REQ-003 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and GAP. The state register SHALL be the only source of the shift_en, shift_in, busy, din_ready and frame_done decodes (Moore outputs), together with the captured word and the bit index.
REQ-004 A word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1. din SHALL be captured into an internal 4-bit hold register on that edge, and the state SHALL move IDLE->START.
REQ-005 din_ready SHALL be 1 only in IDLE. din and din_valid SHALL be ignored in every other state.
REQ-006 Latency: the start bit SHALL appear on shift_in in the cycle immediately following the accepting edge.
REQ-007 The frame SHALL be sent in this order, one bit per cycle, with shift_en=1 for every frame bit:
- start bit 0
- din[0], din[1], din[2], din[3] (LSB first)
- optional parity bit (see REQ-015)
- stop bit 1
REQ-008 A 2-bit index SHALL select the data bit in DATA. DATA SHALL last exactly 4 cycles. Index 3 SHALL go to PARITY when it is compiled in, otherwise to STOP.
REQ-009 frame_done SHALL be 1 exactly during the STOP cycle.
REQ-010 STOP SHALL go to GAP when GAP_CYCLES>0, or directly to IDLE when GAP_CYCLES=0. GAP SHALL last exactly GAP_CYCLES cycles, counted by a 4-bit down-counter, and then go to IDLE.
REQ-011 In IDLE and GAP the outputs SHALL be shift_en=0 and shift_in=1 (line idles high). busy SHALL be 1 in every state except IDLE.
REQ-012 Back-to-back throughput: a word presented continuously SHALL be accepted in the first IDLE cycle after the previous frame. The period between start bits SHALL be frame length + GAP_CYCLES + 1 cycles.
REQ-013 Changes to din after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-014 When rst=1, the block SHALL asynchronously, with no clock required, force:
- state to IDLE
- hold register, bit index and gap counter to 0
- outputs to din_ready=1, shift_en=0, shift_in=1, busy=0, frame_done=0

An assertion mid-frame SHALL abort the frame with no further frame bits. After rst deasserts, the first accept SHALL follow REQ-004.

Configuration
REQ-015 The macro SHIFT_FRAMER_PARITY_EN SHALL control the parity bit:
- Defined: the PARITY state SHALL exist and emit even parity, the XOR of the 4 captured bits, as one bit after din[3]. Frame length is 7 bits.
- Not defined: the PARITY state and its logic SHALL be absent. Frame length is 6 bits.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset: assert rst=1 mid-DATA -> in the same cycle shift_en=0, shift_in=1, busy=0, din_ready=1; the next accept produces a full frame.
- Single word, parity enabled, GAP_CYCLES=1: din=4'b1010 accepted -> shift_in sequence 0,0,1,0,1,0,1 with shift_en=1 for 7 cycles; frame_done=1 on cycle 7 only; then 1 gap cycle; then din_ready=1.
- Single word, parity disabled: din=4'b0111 -> shift_in sequence 0,1,1,1,0,1 over 6 cycles; no parity cycle.
- Back-to-back, GAP_CYCLES=0, parity enabled: din_valid held 1 with 4'b0001 then 4'b1111 -> start bits 8 cycles apart; parity bits 1 then 0.
- Hold-register check: din changed from 4'b1100 to 4'b0011 one cycle after acceptance -> transmitted data bits remain 0,0,1,1.
- Downstream pairing: outputs wired to the 4-bit shift register with din=4'b1010 -> after the stop bit its contents equal the last 4 frame bits shifted in.

Source files
------------

// File: rtl/shift_framer.sv
// Serialises a 4-bit word into a start/data/stop frame for a downstream shift register.
// Define SHIFT_FRAMER_PARITY_EN to add an even-parity bit after din[3].
module shift_framer #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       shift_en,
  output logic       shift_in,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SHIFT_FRAMER_PARITY_EN
    PARITY,
`endif
    STOP,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;

  logic din_ready_d, shift_en_d, shift_in_d, busy_d, frame_done_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (din_valid && din_ready) begin
          hold_d  = din;
          state_d = START;
        end
      end
      START: begin
        idx_d   = 2'd0;
        state_d = DATA;
      end
      DATA: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
`ifdef SHIFT_FRAMER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SHIFT_FRAMER_PARITY_EN
      PARITY: state_d = STOP;
`endif
      STOP: begin
        if (GAP_CYCLES != 0) begin
          gap_d   = 4'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: outputs are decoded from the next state and registered, so they are
  // glitch-free Moore outputs that change on the same edge as the state.
  always_comb begin
    din_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == STOP);
    shift_en_d   = 1'b0;
    shift_in_d   = 1'b1;
    case (state_d)
      START: begin
        shift_en_d = 1'b1;
        shift_in_d = 1'b0;
      end
      DATA: begin
        shift_en_d = 1'b1;
        shift_in_d = hold_d[idx_d];
      end
`ifdef SHIFT_FRAMER_PARITY_EN
      PARITY: begin
        shift_en_d = 1'b1;
        shift_in_d = ^hold_d;
      end
`endif
      STOP:    shift_en_d = 1'b1;
      default: shift_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= 4'd0;
      idx_q      <= 2'd0;
      gap_q      <= 4'd0;
      din_ready  <= 1'b1;
      shift_en   <= 1'b0;
      shift_in   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      din_ready  <= din_ready_d;
      shift_en   <= shift_en_d;
      shift_in   <= shift_in_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_shift_framer.sv
// Self-checking bench for shift_framer: one instance with GAP_CYCLES=1, one with GAP_CYCLES=0.
// Follows the SHIFT_FRAMER_PARITY_EN build setting for the expected frame.
module tb_shift_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [1:0] vld, rdy, en, sin, bsy, done;
  logic [3:0] sr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_start [2];
  bit b2b_pending [2];

`ifdef SHIFT_FRAMER_PARITY_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif
  bit exp_bits [0:6];

  always #5 clk = ~clk;

  shift_framer #(.GAP_CYCLES(1)) dut_g1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(vld[0]), .din_ready(rdy[0]),
    .shift_en(en[0]), .shift_in(sin[0]), .busy(bsy[0]), .frame_done(done[0])
  );

  shift_framer #(.GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(vld[1]), .din_ready(rdy[1]),
    .shift_en(en[1]), .shift_in(sin[1]), .busy(bsy[1]), .frame_done(done[1])
  );

  // Downstream 4-bit shift register fed by the GAP_CYCLES=1 instance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr <= 4'd0;
    else if (en[0]) sr <= {sin[0], sr[3:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  task automatic build(input logic [3:0] w);
    int ones;
    ones = 0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_bits[1 + i] = w[i];
      if (w[i]) ones++;
    end
`ifdef SHIFT_FRAMER_PARITY_EN
    exp_bits[5] = (ones % 2) == 1;
`endif
    exp_bits[FLEN - 1] = 1'b1;
  endtask

  task automatic send(input int s, input logic [3:0] w, input bit chg,
                      input logic [3:0] w2, input bit keep);
    int g;
    g = (s == 0) ? 1 : 0;
    build(w);
    check("rdy_before_accept", rdy[s], 1);
    din    = w;
    vld[s] = 1'b1;
    tick();
    if (!keep) vld[s] = 1'b0;
    if (chg) din = w2;
    if (b2b_pending[s]) check("start_period", cyc - last_start[s], FLEN + g + 1);
    last_start[s] = cyc;
    for (int i = 0; i < FLEN; i++) begin
      check("frame_en", en[s], 1);
      check("frame_bit", sin[s], exp_bits[i]);
      check("frame_busy", bsy[s], 1);
      check("frame_rdy", rdy[s], 0);
      check("frame_done", done[s], (i == FLEN - 1) ? 1 : 0);
      tick();
    end
    for (int j = 0; j < g; j++) begin
      check("gap_en", en[s], 0);
      check("gap_line", sin[s], 1);
      check("gap_busy", bsy[s], 1);
      check("gap_rdy", rdy[s], 0);
      tick();
    end
    check("idle_rdy", rdy[s], 1);
    check("idle_busy", bsy[s], 0);
    check("idle_en", en[s], 0);
    check("idle_line", sin[s], 1);
    b2b_pending[s] = keep;
  endtask

  initial begin
    logic [3:0] expect_sr;
    rst = 1'b1;
    din = 4'd0;
    vld = 2'b00;
    b2b_pending[0] = 0;
    b2b_pending[1] = 0;
    #3;
    check("reset_rdy", rdy[0], 1);
    check("reset_en", en[0], 0);
    check("reset_line", sin[0], 1);
    check("reset_busy", bsy[0], 0);
    check("reset_done", done[1], 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single word on GAP_CYCLES=1, also drives the downstream shift register.
    send(0, 4'b1010, 0, 4'b0000, 0);
    expect_sr = {exp_bits[FLEN - 1], exp_bits[FLEN - 2], exp_bits[FLEN - 3], exp_bits[FLEN - 4]};
    check("downstream_sr", sr, expect_sr);

    send(0, 4'b0111, 0, 4'b0000, 0);

    // Back-to-back on GAP_CYCLES=0 with din_valid held.
    send(1, 4'b0001, 0, 4'b0000, 1);
    send(1, 4'b1111, 0, 4'b0000, 0);

    // din changes right after acceptance; frame must use the captured word.
    send(0, 4'b1100, 1, 4'b0011, 0);

    // Reset asserted mid-DATA aborts the frame immediately.
    din    = 4'b1010;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    tick();
    tick();
    check("pre_abort_en", en[0], 1);
    rst = 1'b1;
    #1;
    check("abort_en", en[0], 0);
    check("abort_line", sin[0], 1);
    check("abort_busy", bsy[0], 0);
    check("abort_rdy", rdy[0], 1);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_abort_en", en[0], 0);
      check("post_abort_busy", bsy[0], 0);
    end
    send(0, 4'b1010, 0, 4'b0000, 0);

    // Randomised words, instances, mid-frame din changes and back-to-back pairs.
    for (int n = 0; n < 40; n++) begin
      int s;
      logic [3:0] w, w2;
      bit chg;
      s   = int'($urandom_range(0, 1));
      w   = 4'($urandom);
      w2  = 4'($urandom);
      chg = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send(s, w, chg, w2, 1);
        send(s, 4'($urandom), 0, 4'd0, 0);
      end else begin
        send(s, w, chg, w2, 0);
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
